// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Pixel-timing master for the VGA display path.
//   * Divides the system clock into a one-clock pixel enable (p_tick_o).
//   * Runs the horizontal / vertical raster counters and publishes them as
//     pix_x_o / pix_y_o together with video_on_o and a frame_start_o pulse
//     for the overlay renderers.
//   * Takes the renderer colour back in (rgb_in_i, registered one clock after
//     the coordinate it belongs to) and drives the monitor pins hsync_o,
//     vsync_o and rgb_o. Sync and colour both trail the coordinates by
//     exactly PIPE clocks so they stay aligned per clock.
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   rgb_in_i[11:0] renderer colour (one clock behind the coordinates)
//   pix_x_o[9:0]   horizontal counter, 0..H_TOTAL-1
//   pix_y_o[9:0]   vertical counter,   0..V_TOTAL-1
//   video_on_o     high inside the active area (combinational from counters)
//   p_tick_o       one-clock pixel enable
//   frame_start_o  one-clock pulse in the first clock the counters read (0,0)
//   hsync_o        horizontal sync, active-low, PIPE clocks behind pix_x_o
//   vsync_o        vertical sync, active-low, PIPE clocks behind pix_y_o
//   rgb_o[11:0]    monitor colour, forced to zero during blanking
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int TICK_DIV  = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int PIPE      = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [11:0] rgb_in_i,
    output logic [9:0]  pix_x_o,
    output logic [9:0]  pix_y_o,
    output logic        video_on_o,
    output logic        p_tick_o,
    output logic        frame_start_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [11:0] rgb_o
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int TW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [9:0]    H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0]    V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0]    HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]    HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]    VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]    VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [TW-1:0]   tick_q, tick_d;
    logic            p_tick_q, p_tick_d;
    logic [9:0]      h_q, h_d;
    logic [9:0]      v_q, v_d;
    logic            frame_q, frame_d;
    logic [PIPE-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE-1:0] vs_pipe_q, vs_pipe_d;
    logic [11:0]     rgb_q, rgb_d;

    logic            tick_wrap_s;
    logic            h_wrap_s;
    logic            v_wrap_s;
    logic            video_on_s;
    logic            hsync_raw_s;
    logic            vsync_raw_s;
    logic            von_d_s;

    // End-of-range detection for the three counters
    always_comb begin
        tick_wrap_s = (tick_q == TICK_MAX);
        h_wrap_s    = (h_q == H_MAX);
        v_wrap_s    = (v_q == V_MAX);
    end

    // Tick divider next state; p_tick is registered from the next tick value
    // so that it is high exactly while tick_q sits at TICK_MAX.
    always_comb begin
        tick_d = tick_q;
        if (tick_wrap_s) begin
            tick_d = {TW{1'b0}};
        end else begin
            tick_d = tick_q + TW'(1'b1);
        end
        p_tick_d = (tick_d == TICK_MAX);
    end

    // Raster counter next state. Horizontal and vertical wrap on the same
    // edge at the end of a frame, so (0,0) follows (H_MAX,V_MAX) directly.
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        frame_d = 1'b0;
        if (tick_wrap_s) begin
            if (h_wrap_s) begin
                h_d = 10'd0;
                if (v_wrap_s) begin
                    v_d     = 10'd0;
                    frame_d = 1'b1;
                end else begin
                    v_d     = v_q + 10'd1;
                    frame_d = 1'b0;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end else begin
            h_d = h_q;
        end
    end

    // Tick divider and raster counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tick_q   <= {TW{1'b0}};
            p_tick_q <= 1'b0;
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            // Armed during reset so the pulse lands in the first clock after
            // release, when the counters first read (0,0) as live values.
            frame_q  <= 1'b1;
        end else begin
            tick_q   <= tick_d;
            p_tick_q <= p_tick_d;
            h_q      <= h_d;
            v_q      <= v_d;
            frame_q  <= frame_d;
        end
    end

    // Active-area and raw sync decode from the live counters
    always_comb begin
        video_on_s  = (h_q < H_DISP) && (v_q < V_DISP);
        hsync_raw_s = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
        vsync_raw_s = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    end

    // -----------------------------------------------------------------------
    // Sync delay line: PIPE stages so sync reaches the pins together with the
    // colour belonging to the same coordinate.
    // -----------------------------------------------------------------------
    generate
        if (PIPE == 1) begin : g_sync_single
            // Single stage: the register takes the raw sync directly
            always_comb begin
                hs_pipe_d = hsync_raw_s;
                vs_pipe_d = vsync_raw_s;
            end
        end else begin : g_sync_shift
            // Multi-stage shift, stage 0 takes the raw sync
            always_comb begin
                hs_pipe_d = {hs_pipe_q[PIPE-2:0], hsync_raw_s};
                vs_pipe_d = {vs_pipe_q[PIPE-2:0], vsync_raw_s};
            end
        end
    endgenerate

    // Sync delay registers; idle level is high (inactive)
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hs_pipe_q <= {PIPE{1'b1}};
            vs_pipe_q <= {PIPE{1'b1}};
        end else begin
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
        end
    end

    // -----------------------------------------------------------------------
    // video_on delay line: PIPE-1 stages. The renderer register supplies the
    // remaining stage on the colour path, so von_d_s lines up with rgb_in_i.
    // -----------------------------------------------------------------------
    generate
        if (PIPE > 1) begin : g_von_pipe
            logic [PIPE-2:0] von_pipe_q;
            logic [PIPE-2:0] von_pipe_d;

            if (PIPE == 2) begin : g_von_single
                // One stage: takes video_on directly
                always_comb begin
                    von_pipe_d = video_on_s;
                end
            end else begin : g_von_shift
                // Shift toward the tap, stage 0 takes video_on
                always_comb begin
                    von_pipe_d = {von_pipe_q[PIPE-3:0], video_on_s};
                end
            end

            // video_on delay registers; blank while in reset
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    von_pipe_q <= {(PIPE-1){1'b0}};
                end else begin
                    von_pipe_q <= von_pipe_d;
                end
            end

            assign von_d_s = von_pipe_q[PIPE-2];
        end else begin : g_von_bypass
            assign von_d_s = video_on_s;
        end
    endgenerate

    // Colour gating: renderer colour only inside the delayed active area
    always_comb begin
        rgb_d = 12'h000;
        if (von_d_s) begin
            rgb_d = rgb_in_i;
        end else begin
            rgb_d = 12'h000;
        end
    end

    // Colour output register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign pix_x_o    = h_q;
    assign pix_y_o    = v_q;
    assign video_on_o = video_on_s;
    assign p_tick_o   = p_tick_q;
    // frame_q is armed by reset; masking with reset_i keeps the pulse low for
    // as long as reset is held and lets it appear on the first free clock.
    assign frame_start_o = frame_q & ~reset_i;
    assign hsync_o    = hs_pipe_q[PIPE-1];
    assign vsync_o    = vs_pipe_q[PIPE-1];
    assign rgb_o      = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default-parameter instance
    logic        rst_a;
    logic [11:0] rgbin_a;
    logic [9:0]  x_a, y_a;
    logic        von_a, pt_a, fs_a, hs_a, vs_a;
    logic [11:0] rgb_a;

    vga_timing_gen dut_a (
        .clk_i(clk), .reset_i(rst_a), .rgb_in_i(rgbin_a),
        .pix_x_o(x_a), .pix_y_o(y_a), .video_on_o(von_a), .p_tick_o(pt_a),
        .frame_start_o(fs_a), .hsync_o(hs_a), .vsync_o(vs_a), .rgb_o(rgb_a)
    );

    // Sweep instance: TICK_DIV=2, PIPE=1, short frame (V_TOTAL=8)
    logic        rst_b;
    logic [11:0] rgbin_b;
    logic [9:0]  x_b, y_b;
    logic        von_b, pt_b, fs_b, hs_b, vs_b;
    logic [11:0] rgb_b;

    vga_timing_gen #(
        .TICK_DIV(2), .PIPE(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_b (
        .clk_i(clk), .reset_i(rst_b), .rgb_in_i(rgbin_b),
        .pix_x_o(x_b), .pix_y_o(y_b), .video_on_o(von_b), .p_tick_o(pt_b),
        .frame_start_o(fs_b), .hsync_o(hs_b), .vsync_o(vs_b), .rgb_o(rgb_b)
    );

    // Expected raster for dut_a, k = clocks since its frame_start
    function automatic logic [9:0] ax(input int k);
        return 10'((k / 4) % 800);
    endfunction
    function automatic logic [9:0] ay(input int k);
        return 10'((k / 3200) % 525);
    endfunction
    function automatic logic avon(input int k);
        return (ax(k) < 10'd640) && (ay(k) < 10'd480);
    endfunction
    function automatic logic ahs(input int k);
        if (k < 2) return 1'b1;
        return !((ax(k - 2) >= 10'd656) && (ax(k - 2) <= 10'd751));
    endfunction

    // Expected raster for dut_b
    function automatic logic [9:0] bx(input int k);
        return 10'((k / 2) % 800);
    endfunction
    function automatic logic [9:0] by(input int k);
        return 10'((k / 1600) % 8);
    endfunction
    function automatic logic bvon(input int k);
        return (bx(k) < 10'd640) && (by(k) < 10'd4);
    endfunction
    function automatic logic bhs(input int k);
        if (k < 1) return 1'b1;
        return !((bx(k - 1) >= 10'd656) && (bx(k - 1) <= 10'd751));
    endfunction
    function automatic logic bvs(input int k);
        if (k < 1) return 1'b1;
        return !((by(k - 1) >= 10'd5) && (by(k - 1) <= 10'd6));
    endfunction

    task automatic restart_a();
        @(posedge clk); #1 rst_a = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rst_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [36:0] got;
        logic [36:0] exp;
        rgbin_a = 12'hFFF;
        rst_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        got = {fs_a, pt_a, von_a, hs_a, vs_a, x_a, y_a, rgb_a};
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 12'h000};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_release: got %h want %h", got, exp); end
        for (int k = 1; k <= 4400; k++) begin
            @(posedge clk); #1; @(negedge clk);
            if (k == 1) begin
                checks++;
                if ({fs_a, pt_a, rgb_a} !== {1'b0, 1'b0, 12'h000}) begin
                    errors++; $display("FAIL first_clocks k=1: got fs=%b pt=%b rgb=%h want 0 0 000", fs_a, pt_a, rgb_a);
                end
            end
            if (k == 2) begin
                checks++;
                if ({pt_a, rgb_a} !== {1'b0, 12'hFFF}) begin
                    errors++; $display("FAIL first_clocks k=2: got pt=%b rgb=%h want 0 fff", pt_a, rgb_a);
                end
            end
            if (k == 3) begin
                checks++;
                if (pt_a !== 1'b1) begin errors++; $display("FAIL first_ptick: got %b want 1", pt_a); end
            end
            if (k == 4400) begin
                checks++;
                if ({x_a, y_a, rgb_a} !== {10'd300, 10'd1, 12'hFFF}) begin
                    errors++; $display("FAIL midframe_pos: got x=%0d y=%0d rgb=%h want 300 1 fff", x_a, y_a, rgb_a);
                end
            end
        end
        // Assert reset mid-frame; it only takes effect on the next edge
        @(posedge clk); #1 rst_a = 1'b1;
        @(negedge clk);
        checks++;
        if ({fs_a, x_a} !== {1'b0, 10'd300}) begin
            errors++; $display("FAIL reset_sync: got fs=%b x=%0d want 0 300", fs_a, x_a);
        end
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 5) rst_a = 1'b0;
            @(negedge clk);
            got = {fs_a, pt_a, von_a, hs_a, vs_a, x_a, y_a, rgb_a};
            exp = {(i == 5), 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 12'h000};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_hold i=%0d: got %h want %h", i, got, exp); end
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1; @(negedge clk);
            checks++;
            if ({fs_a, pt_a} !== {1'b0, (k == 3)}) begin
                errors++; $display("FAIL rerelease_ptick k=%0d: got fs=%b pt=%b want 0 %b", k, fs_a, pt_a, (k == 3));
            end
        end
    endtask

    task automatic test_line();
        int xerr = 0, perr = 0, fserr = 0, hserr = 0, pcnt = 0, hs_start = -1, hs_len = 0;
        restart_a();
        for (int k = 0; k <= 3200; k++) begin
            if (k > 0) begin @(posedge clk); #1; @(negedge clk); end
            if ({x_a, y_a} !== {ax(k), ay(k)}) xerr++;
            if (pt_a !== ((k % 4) == 3)) perr++;
            if (fs_a !== (k == 0)) fserr++;
            if (hs_a !== ahs(k)) hserr++;
            if (k < 3200 && pt_a === 1'b1) pcnt++;
            if (hs_a === 1'b0) begin
                hs_len++;
                if (hs_start < 0) hs_start = k;
            end
            if (k == 3199) begin
                checks++;
                if (x_a !== 10'd799) begin errors++; $display("FAIL line_last_x: got %0d want 799", x_a); end
            end
            if (k == 3200) begin
                checks++;
                if ({x_a, y_a} !== {10'd0, 10'd1}) begin
                    errors++; $display("FAIL line_wrap: got x=%0d y=%0d want 0 1", x_a, y_a);
                end
            end
        end
        checks++; if (xerr !== 0) begin errors++; $display("FAIL line_xy: got %0d bad clocks want 0", xerr); end
        checks++; if (perr !== 0) begin errors++; $display("FAIL line_ptick: got %0d bad clocks want 0", perr); end
        checks++; if (fserr !== 0) begin errors++; $display("FAIL line_fs: got %0d bad clocks want 0", fserr); end
        checks++; if (hserr !== 0) begin errors++; $display("FAIL line_hsync: got %0d bad clocks want 0", hserr); end
        checks++; if (pcnt !== 800) begin errors++; $display("FAIL line_ptick_cnt: got %0d want 800", pcnt); end
        checks++; if (hs_start !== 2626) begin errors++; $display("FAIL hsync_start: got %0d want 2626", hs_start); end
        checks++; if (hs_len !== 384) begin errors++; $display("FAIL hsync_len: got %0d want 384", hs_len); end
    endtask

    task automatic test_blank();
        int rerr = 0, verr = 0;
        logic [11:0] exp;
        rgbin_a = 12'hFFF;
        restart_a();
        for (int k = 0; k <= 3203; k++) begin
            if (k > 0) begin @(posedge clk); #1; @(negedge clk); end
            exp = (k >= 2 && avon(k - 2)) ? 12'hFFF : 12'h000;
            if (rgb_a !== exp) rerr++;
            if (von_a !== avon(k)) verr++;
            if (k == 2561 || k == 2562 || k == 3202) begin
                checks++;
                if (rgb_a !== exp) begin errors++; $display("FAIL blank_edge k=%0d: got %h want %h", k, rgb_a, exp); end
            end
        end
        checks++; if (rerr !== 0) begin errors++; $display("FAIL blank_rgb: got %0d bad clocks want 0", rerr); end
        checks++; if (verr !== 0) begin errors++; $display("FAIL video_on: got %0d bad clocks want 0", verr); end
    endtask

    task automatic test_align();
        int aerr = 0;
        logic [9:0]  prev_x;
        logic [11:0] exp;
        restart_a();
        prev_x = x_a;
        for (int k = 0; k <= 3210; k++) begin
            if (k > 0) begin
                @(posedge clk); #1 rgbin_a = {prev_x, 2'b00};
                @(negedge clk);
                prev_x = x_a;
            end
            exp = (k >= 2 && avon(k - 2)) ? {ax(k - 2), 2'b00} : 12'h000;
            if (rgb_a !== exp) aerr++;
            if (k == 2561 || k == 2562 || k == 3205 || k == 3206) begin
                checks++;
                if (rgb_a !== exp) begin errors++; $display("FAIL align_edge k=%0d: got %h want %h", k, rgb_a, exp); end
            end
        end
        checks++; if (aerr !== 0) begin errors++; $display("FAIL align_rgb: got %0d bad clocks want 0", aerr); end
    endtask

    task automatic test_sweep();
        int xerr = 0, perr = 0, serr = 0, rerr = 0, fcnt = 0;
        int hs_start = -1, vs_start = -1, vs_len = 0, rgb_fall = -1;
        logic [9:0]  ymax = 10'd0;
        logic [11:0] exp;
        rgbin_b = 12'hFFF;
        @(posedge clk); #1 rst_b = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rst_b = 1'b0;
        @(negedge clk);
        for (int k = 0; k <= 25600; k++) begin
            if (k > 0) begin @(posedge clk); #1; @(negedge clk); end
            if ({x_b, y_b} !== {bx(k), by(k)}) xerr++;
            if (pt_b !== ((k % 2) == 1)) perr++;
            if (fs_b !== ((k % 12800) == 0)) perr++;
            if (fs_b === 1'b1) fcnt++;
            if ({hs_b, vs_b} !== {bhs(k), bvs(k)}) serr++;
            exp = (k >= 1 && bvon(k - 1)) ? 12'hFFF : 12'h000;
            if (rgb_b !== exp) rerr++;
            if (y_b > ymax) ymax = y_b;
            if (hs_b === 1'b0 && hs_start < 0) hs_start = k;
            if (k >= 1 && rgb_b === 12'h000 && rgb_fall < 0) rgb_fall = k;
            if (k < 12800 && vs_b === 1'b0) begin
                vs_len++;
                if (vs_start < 0) vs_start = k;
            end
            if (k == 1600) begin
                checks++;
                if ({x_b, y_b} !== {10'd0, 10'd1}) begin
                    errors++; $display("FAIL sweep_line_wrap: got x=%0d y=%0d want 0 1", x_b, y_b);
                end
            end
        end
        checks++; if (xerr !== 0) begin errors++; $display("FAIL sweep_xy: got %0d bad clocks want 0", xerr); end
        checks++; if (perr !== 0) begin errors++; $display("FAIL sweep_tick_fs: got %0d bad clocks want 0", perr); end
        checks++; if (serr !== 0) begin errors++; $display("FAIL sweep_sync: got %0d bad clocks want 0", serr); end
        checks++; if (rerr !== 0) begin errors++; $display("FAIL sweep_rgb: got %0d bad clocks want 0", rerr); end
        checks++; if (fcnt !== 3) begin errors++; $display("FAIL sweep_frames: got %0d want 3", fcnt); end
        checks++; if (ymax !== 10'd7) begin errors++; $display("FAIL sweep_ymax: got %0d want 7", ymax); end
        checks++; if (hs_start !== 1313) begin errors++; $display("FAIL sweep_hs_start: got %0d want 1313", hs_start); end
        checks++; if (rgb_fall !== 1281) begin errors++; $display("FAIL sweep_rgb_fall: got %0d want 1281", rgb_fall); end
        checks++; if (vs_start !== 8001) begin errors++; $display("FAIL sweep_vs_start: got %0d want 8001", vs_start); end
        checks++; if (vs_len !== 3200) begin errors++; $display("FAIL sweep_vs_len: got %0d want 3200", vs_len); end
    endtask

    // Watchdog: the sequence needs well under 50k clocks
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        rgbin_a = 12'hFFF;
        rgbin_b = 12'hFFF;
        test_reset();
        test_line();
        test_blank();
        test_align();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing master for the VGA display path. Divides the system clock into a pixel-rate enable and generates horizontal/vertical counters, `pix_x`/`pix_y`/`video_on`, and frame events for the overlay renderers. It also closes the loop on the other side: it accepts their registered `rgbtext` colour and drives the monitor-facing `hsync`, `vsync` and `rgb` outputs, delayed so colour and sync stay pixel-aligned. Default timing is 640x480 at 60 Hz from a 100 MHz clock.

## Interface
- `TICK_DIV`, 4: system clocks per pixel; must be 2 or more.
- `H_DISPLAY`, 640: active pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: active lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `PIPE`, 2: clocks of delay from coordinates to pins; must be 1 or more. It counts the renderer register plus the output register.
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `rgb_in`, in, 12: renderer colour, registered by the renderer one clock after the coordinates it belongs to.
- `pix_x`, out, 10: horizontal counter, 0..H_TOTAL-1.
- `pix_y`, out, 10: vertical counter, 0..V_TOTAL-1.
- `video_on`, out, 1: high when `pix_x` < H_DISPLAY and `pix_y` < V_DISPLAY; combinational from the counters.
- `p_tick`, out, 1: one-clock pixel enable.
- `frame_start`, out, 1: one-clock pulse when the counters become (0,0).
- `hsync`, out, 1: horizontal sync to the monitor, active-low.
- `vsync`, out, 1: vertical sync to the monitor, active-low.
- `rgb`, out, 12: colour to the monitor; forced to 0 during blanking.

## Operation
- Totals: H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK (800 by default). V_TOTAL is defined the same way from the vertical parameters (525 by default).
- Tick counter: `tick_cnt` counts 0..TICK_DIV-1 and wraps. `p_tick` is high exactly when `tick_cnt` == TICK_DIV-1.
- Horizontal counter: on `p_tick`, `h_cnt` increments. At H_TOTAL-1 it wraps to 0 and `v_cnt` increments.
- Vertical counter: `v_cnt` wraps to 0 when it is at V_TOTAL-1 and `h_cnt` wraps. Both counters therefore wrap on the same clock at the end of a frame.
- Coordinate outputs: `pix_x` = `h_cnt` and `pix_y` = `v_cnt`. Each value holds for TICK_DIV clocks.
- Raw hsync: low while `h_cnt` is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], which is [656,751] by default.
- Raw vsync: low while `v_cnt` is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], which is [490,491] by default.
- Sync pipeline: raw hsync and vsync each pass through a PIPE-stage shift register before reaching `hsync` and `vsync`.
- Colour gating: `video_on` is delayed through PIPE-1 stages to give `von_d`. Each clock, the output register loads `rgb` ← `von_d` ? `rgb_in` : 12'h000.
- frame_start: registered pulse, high for one clock in the first clock the counters read (0,0). This covers both the frame wrap and the first clock after reset deasserts.
- Arithmetic: all counters are unsigned and wrap only by explicit compare, never by overflow. Widths of 10 bits cover H_TOTAL and V_TOTAL up to 1023.

## Timing
Reset (synchronous, any cycle, including mid-frame) acts on the next clock edge:
- `tick_cnt`, `h_cnt` and `v_cnt` clear to 0, so `pix_x`=0, `pix_y`=0 and `video_on`=1.
- `p_tick`=0.
- `frame_start`=0 while reset is held.
- Every sync pipeline stage loads 1, so `hsync`=1 and `vsync`=1.
- Every `von_d` stage loads 0, and `rgb`=0.

Cycle-level behaviour:
- Exit from reset: on the first clock after reset drops, `frame_start`=1 and `tick_cnt`=0. The first `p_tick` arrives TICK_DIV-1 clocks after that.
- Line and frame periods: one line is H_TOTAL×TICK_DIV clocks (3200 by default). One frame is V_TOTAL lines (1,680,000 clocks by default).
- Pixel alignment: the coordinate-to-colour and coordinate-to-sync latencies are both exactly PIPE clocks. Because each coordinate holds for TICK_DIV clocks (≥ PIPE is not required), alignment is per clock, not per tick.
- Counter/tick coincidence: `p_tick` and the counter update happen on the same edge. The new coordinate is visible on the clock after `p_tick`.
- Simultaneous wrap: when `h_cnt` and `v_cnt` wrap on the same edge, there is no intermediate (0, V_TOTAL-1) or (H_TOTAL-1, 0) state. The counters go straight to (0,0).

## Test plan
- Reset values: hold reset for 5 clocks mid-frame (`h_cnt`=300, `v_cnt`=200). On release, `pix_x`=0, `pix_y`=0, `hsync`=1, `vsync`=1, `rgb`=0, `frame_start` pulses once, and the first `p_tick` follows 3 clocks later.
- Line timing: measure from `frame_start` over one line. `p_tick` fires every 4 clocks. `pix_x` steps 0..799 then 0. Delayed `hsync` goes low for 384 clocks, starting 656×4+2 clocks after `pix_x` first reads 0.
- Frame timing: `vsync` is low for 2×3200 clocks, on lines 490–491 (PIPE delayed). `frame_start` pulses recur every 1,680,000 clocks. `pix_y` never exceeds 524.
- Blanking: drive `rgb_in`=12'hFFF constantly. `rgb`=12'hFFF exactly while the delayed `video_on`=1 and 12'h000 otherwise. `rgb` first reads 0 two clocks after `pix_x` reaches 640.
- Alignment: `rgb_in` is a one-clock-registered copy of {`pix_x`[9:0], 2'b00}. At the pins, `rgb` equals the coordinate that was present PIPE clocks earlier, including across the line wrap at 799→0.
- Parameter sweep: with TICK_DIV=2 and PIPE=1, the line is 1600 clocks and `hsync` leads `rgb` changes by 0 clocks.
